// File: rtl/sram_arb_ctrl.sv
// Round-robin two-master controller for an asynchronous 128K x 8 SRAM.
// Sequences CS/OE/WE through SETUP/ACCESS/HOLD with registered pin outputs.
module sram_arb_ctrl #(
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 6
) (
  input  logic              FPGA_CLK,
  input  logic              FPGA_RST,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_done,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_done,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d_o,
  output logic              sram_d_oe,
  input  logic [DATA_W-1:0] sram_d_i,
  output logic              sram_cs1_b,
  output logic              sram_cs2,
  output logic              sram_oe_b,
  output logic              sram_we_b
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                last_b_q, last_b_d;
  logic                own_b_q, own_b_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                a_done_q, a_done_d;
  logic                b_done_q, b_done_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;

  logic                cs1_b_q, cs1_b_d;
  logic                cs2_q, cs2_d;
  logic                oe_b_q, oe_b_d;
  logic                we_b_q, we_b_d;
  logic [ADDR_W-1:0]   sram_a_q, sram_a_d;
  logic [DATA_W-1:0]   d_o_q, d_o_d;
  logic                d_oe_q, d_oe_d;

  logic                any_req_s;
  logic                pick_b_s;

  // B wins only when A is idle or A was the last one served.
  assign any_req_s = a_req | b_req;
  assign pick_b_s  = b_req & (~a_req | ~last_b_q);
  assign a_gnt     = ~FPGA_RST & (state_q == ST_IDLE) & any_req_s & ~pick_b_s;
  assign b_gnt     = ~FPGA_RST & (state_q == ST_IDLE) & pick_b_s;

  assign a_done     = a_done_q;
  assign b_done     = b_done_q;
  assign a_rdata    = a_rdata_q;
  assign b_rdata    = b_rdata_q;
  assign sram_a     = sram_a_q;
  assign sram_d_o   = d_o_q;
  assign sram_d_oe  = d_oe_q;
  assign sram_cs1_b = cs1_b_q;
  assign sram_cs2   = cs2_q;
  assign sram_oe_b  = oe_b_q;
  assign sram_we_b  = we_b_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_b_d  = last_b_q;
    own_b_d   = own_b_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_done_d  = 1'b0;
    b_done_d  = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          state_d  = ST_SETUP;
          last_b_d = pick_b_s;
          own_b_d  = pick_b_s;
          we_d     = pick_b_s ? b_we    : a_we;
          addr_d   = pick_b_s ? b_addr  : a_addr;
          wdata_d  = pick_b_s ? b_wdata : a_wdata;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_d   = CNT_LOAD;
      end
      ST_ACCESS: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_HOLD;
          // Read data is sampled while OE is still low, on the final access edge.
          if (!we_q) begin
            if (own_b_q) begin
              b_rdata_d = sram_d_i;
            end else begin
              a_rdata_d = sram_d_i;
            end
          end else begin
            a_rdata_d = a_rdata_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
        if (own_b_q) begin
          b_done_d = 1'b1;
        end else begin
          a_done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pin values are decoded from the next state so they change on the same edge as the FSM.
  always_comb begin
    cs1_b_d  = 1'b1;
    cs2_d    = 1'b0;
    oe_b_d   = 1'b1;
    we_b_d   = 1'b1;
    sram_a_d = sram_a_q;
    d_o_d    = d_o_q;
    d_oe_d   = 1'b0;
    case (state_d)
      ST_IDLE: begin
        cs1_b_d = 1'b1;
      end
      ST_SETUP: begin
        cs1_b_d  = 1'b0;
        cs2_d    = 1'b1;
        sram_a_d = addr_d;
        d_oe_d   = we_d;
        d_o_d    = we_d ? wdata_d : d_o_q;
      end
      ST_ACCESS: begin
        cs1_b_d = 1'b0;
        cs2_d   = 1'b1;
        oe_b_d  = we_q;
        we_b_d  = ~we_q;
        d_oe_d  = we_q;
      end
      ST_HOLD: begin
        cs1_b_d = 1'b0;
        cs2_d   = 1'b1;
        d_oe_d  = we_q;
      end
      default: begin
        cs1_b_d = 1'b1;
      end
    endcase
  end

  // FSM state, captured request and requester-side outputs.
  always_ff @(posedge FPGA_CLK or posedge FPGA_RST) begin
    if (FPGA_RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_ZERO;
      last_b_q  <= 1'b1;
      own_b_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= {ADDR_W{1'b0}};
      wdata_q   <= {DATA_W{1'b0}};
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      a_rdata_q <= {DATA_W{1'b0}};
      b_rdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_b_q  <= last_b_d;
      own_b_q   <= own_b_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_done_q  <= a_done_d;
      b_done_q  <= b_done_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  // SRAM pin registers.
  always_ff @(posedge FPGA_CLK or posedge FPGA_RST) begin
    if (FPGA_RST) begin
      cs1_b_q  <= 1'b1;
      cs2_q    <= 1'b0;
      oe_b_q   <= 1'b1;
      we_b_q   <= 1'b1;
      sram_a_q <= {ADDR_W{1'b0}};
      d_o_q    <= {DATA_W{1'b0}};
      d_oe_q   <= 1'b0;
    end else begin
      cs1_b_q  <= cs1_b_d;
      cs2_q    <= cs2_d;
      oe_b_q   <= oe_b_d;
      we_b_q   <= we_b_d;
      sram_a_q <= sram_a_d;
      d_o_q    <= d_o_d;
      d_oe_q   <= d_oe_d;
    end
  end

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Bench for sram_arb_ctrl: directed vector table, corner sequences and randomized
// traffic against a memory/arbitration reference model; second instance uses WAIT_CYCLES=1.
module tb_sram_arb_ctrl;
  localparam int AW = 17;
  localparam int DW = 8;
  localparam int WC = 6;

  logic FPGA_CLK = 1'b0;
  logic FPGA_RST;
  always #5 FPGA_CLK = ~FPGA_CLK;

  logic          a_req, a_we, a_gnt, a_done;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_req, b_we, b_gnt, b_done;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d_o, sram_d_i;
  logic          sram_d_oe, sram_cs1_b, sram_cs2, sram_oe_b, sram_we_b;

  logic          c_req, c_we, c_gnt, c_done;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic          d_req, d_we, d_gnt, d_done;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [AW-1:0] s1_a;
  logic [DW-1:0] s1_d_o, s1_d_i;
  logic          s1_d_oe, s1_cs1_b, s1_cs2, s1_oe_b, s1_we_b;

  sram_arb_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC)) u_dut (
    .FPGA_CLK(FPGA_CLK), .FPGA_RST(FPGA_RST),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
    .sram_a(sram_a), .sram_d_o(sram_d_o), .sram_d_oe(sram_d_oe), .sram_d_i(sram_d_i),
    .sram_cs1_b(sram_cs1_b), .sram_cs2(sram_cs2), .sram_oe_b(sram_oe_b), .sram_we_b(sram_we_b)
  );

  sram_arb_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) u_dut1 (
    .FPGA_CLK(FPGA_CLK), .FPGA_RST(FPGA_RST),
    .a_req(c_req), .a_we(c_we), .a_addr(c_addr), .a_wdata(c_wdata),
    .a_gnt(c_gnt), .a_done(c_done), .a_rdata(c_rdata),
    .b_req(d_req), .b_we(d_we), .b_addr(d_addr), .b_wdata(d_wdata),
    .b_gnt(d_gnt), .b_done(d_done), .b_rdata(d_rdata),
    .sram_a(s1_a), .sram_d_o(s1_d_o), .sram_d_oe(s1_d_oe), .sram_d_i(s1_d_i),
    .sram_cs1_b(s1_cs1_b), .sram_cs2(s1_cs2), .sram_oe_b(s1_oe_b), .sram_we_b(s1_we_b)
  );

  // Asynchronous SRAM pin model: writes while WE is low, drives data only while OE is low.
  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  function automatic logic [DW-1:0] init_pat(input int i);
    return DW'(i) ^ DW'(i >> 8) ^ 8'h3C;
  endfunction

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = init_pat(i);
    mem[16] = 8'hC3;
    forever begin
      @(negedge FPGA_CLK);
      if (!sram_cs1_b && sram_cs2 && !sram_we_b) mem[sram_a] = sram_d_o;
    end
  end
  assign sram_d_i = (!sram_cs1_b && sram_cs2 && !sram_oe_b) ? mem[sram_a] : 8'hEE;
  assign s1_d_i   = (!s1_cs1_b && s1_cs2 && !s1_oe_b) ? (s1_a[7:0] ^ 8'hA5) : 8'hEE;

  // Per-cycle pin monitor: strobe counts and protocol violations.
  int cyc = 0, oe_low = 0, we_low = 0, doe_hi = 0, viol = 0, pin_bad = 0, oe1_low = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wd = '0;
  always @(negedge FPGA_CLK) begin
    cyc <= cyc + 1;
    if (!sram_oe_b) oe_low <= oe_low + 1;
    if (!sram_we_b) we_low <= we_low + 1;
    if (sram_d_oe) doe_hi <= doe_hi + 1;
    if (!s1_oe_b) oe1_low <= oe1_low + 1;
    if ((sram_d_oe && !sram_oe_b) || (s1_d_oe && !s1_oe_b) || (!sram_oe_b && !sram_we_b))
      viol <= viol + 1;
    if ((!sram_oe_b || !sram_we_b) &&
        (sram_a != exp_addr || sram_cs1_b || !sram_cs2 ||
         (!sram_we_b && (sram_d_o != exp_wd || !sram_d_oe))))
      pin_bad <= pin_bad + 1;
  end

  int n_vec = 0;
  int n_err = 0;
  logic exp_last_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_gnt(output logic ga, output logic gb);
    int n = 0;
    #1;
    while (!a_gnt && !b_gnt && n < 60) begin
      @(negedge FPGA_CLK); #1;
      n++;
    end
    ga = a_gnt;
    gb = b_gnt;
    if (!ga && !gb) check("gnt_timeout", 32'd0, 32'd1);
  endtask

  // Called in the grant cycle; follows the transaction to its done and checks it.
  task automatic complete(input logic own_b, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, output logic [DW-1:0] rd);
    int s_oe, s_we, s_doe, s_bad, n, other;
    logic dn;
    exp_addr = addr; exp_wd = wd;
    s_oe = oe_low; s_we = we_low; s_doe = doe_hi; s_bad = pin_bad;
    @(posedge FPGA_CLK); #1;
    if (own_b) b_req = 1'b0; else a_req = 1'b0;
    n = 0; other = 0;
    do begin
      @(negedge FPGA_CLK); #1;
      n++;
      dn = own_b ? b_done : a_done;
      if (own_b ? a_done : b_done) other++;
    end while (!dn && n < 40);
    check("done_latency", n, WC + 3);
    check("other_done", other, 0);
    check("we_low_cycles", we_low - s_we, we ? WC : 0);
    check("oe_low_cycles", oe_low - s_oe, we ? 0 : WC);
    check("d_oe_cycles", doe_hi - s_doe, we ? WC + 2 : 0);
    check("pin_during_strobe", pin_bad - s_bad, 0);
    rd = own_b ? b_rdata : a_rdata;
    if (!we) check("rdata_model", rd, ref_mem[addr]);
    else ref_mem[addr] = wd;
    exp_last_b = own_b;
  endtask

  task automatic issue(input logic own_b, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, output logic [DW-1:0] rd);
    logic ga, gb;
    @(negedge FPGA_CLK);
    if (own_b) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; end
    else begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; end
    wait_gnt(ga, gb);
    check("gnt_owner", {30'd0, ga, gb}, own_b ? 32'd1 : 32'd2);
    complete(own_b, we, addr, wd, rd);
  endtask

  typedef struct {
    logic          own_b;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rd;
  } vec_t;

  initial begin
    #200us;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [10];
    logic [DW-1:0] rd;
    logic ga, gb, pa, pb, eb;
    int gcyc [4];
    logic gwho [4];
    int k, n, cnt, s;

    tbl[0] = '{1'b0, 1'b1, 17'h1ABCD, 8'h5A, 8'h00};
    tbl[1] = '{1'b1, 1'b0, 17'h00010, 8'h00, 8'hC3};
    tbl[2] = '{1'b0, 1'b1, 17'h00100, 8'h77, 8'h00};
    tbl[3] = '{1'b1, 1'b0, 17'h00100, 8'h00, 8'h77};
    tbl[4] = '{1'b0, 1'b0, 17'h1ABCD, 8'h00, 8'h5A};
    tbl[5] = '{1'b1, 1'b1, 17'h1FFFF, 8'hFF, 8'h00};
    tbl[6] = '{1'b0, 1'b0, 17'h1FFFF, 8'h00, 8'hFF};
    tbl[7] = '{1'b1, 1'b0, 17'h00000, 8'h00, 8'h3C};
    tbl[8] = '{1'b0, 1'b1, 17'h00000, 8'h00, 8'h00};
    tbl[9] = '{1'b1, 1'b0, 17'h00000, 8'h00, 8'h00};

    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_pat(i);
    ref_mem[16] = 8'hC3;
    exp_last_b = 1'b1;
    FPGA_RST = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    // Reset values, with a request pending to show grant is suppressed.
    repeat (3) @(negedge FPGA_CLK);
    #1;
    check("rst_cs1_b", sram_cs1_b, 1);
    check("rst_cs2", sram_cs2, 0);
    check("rst_oe_b", sram_oe_b, 1);
    check("rst_we_b", sram_we_b, 1);
    check("rst_a", sram_a, 0);
    check("rst_d_o", sram_d_o, 0);
    check("rst_d_oe", sram_d_oe, 0);
    check("rst_gnt", {30'd0, a_gnt, b_gnt}, 0);
    check("rst_done", {30'd0, a_done, b_done}, 0);
    check("rst_rdata", {16'd0, a_rdata, b_rdata}, 0);
    a_req = 1'b0;
    @(negedge FPGA_CLK);
    FPGA_RST = 1'b0;

    for (int i = 0; i < 10; i++) begin
      issue(tbl[i].own_b, tbl[i].we, tbl[i].addr, tbl[i].wdata, rd);
      if (!tbl[i].we) check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
    end

    // Contention: both requests held high across four back-to-back transactions.
    @(negedge FPGA_CLK); FPGA_RST = 1'b1;
    @(negedge FPGA_CLK); FPGA_RST = 1'b0;
    exp_last_b = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 17'h00020;
    b_req = 1'b1; b_we = 1'b0; b_addr = 17'h00021;
    k = 0; n = 0;
    while (k < 4 && n < 100) begin
      #1;
      if (a_gnt || b_gnt) begin
        gwho[k] = b_gnt;
        gcyc[k] = cyc;
        if (k > 0) check("cont_done_with_gnt", gwho[k-1] ? b_done : a_done, 1);
        k++;
      end
      if (k < 4) begin
        @(negedge FPGA_CLK);
        n++;
      end
    end
    check("cont_grants", k, 4);
    if (k == 4) begin
      for (int i = 0; i < 4; i++) check($sformatf("cont_order%0d", i), gwho[i], i % 2);
      for (int i = 1; i < 4; i++) check($sformatf("cont_spacing%0d", i), gcyc[i] - gcyc[i-1], WC + 3);
    end
    @(posedge FPGA_CLK); #1;
    a_req = 1'b0; b_req = 1'b0;
    n = 0;
    do begin @(negedge FPGA_CLK); #1; n++; end while (!b_done && n < 20);
    check("cont_last_done", b_done, 1);
    check("cont_a_rdata", a_rdata, ref_mem[17'h00020]);
    check("cont_b_rdata", b_rdata, ref_mem[17'h00021]);
    exp_last_b = 1'b1;

    // Reset during the third ACCESS cycle of a write.
    exp_addr = 17'h0ABCD; exp_wd = 8'h99;
    @(negedge FPGA_CLK);
    a_req = 1'b1; a_we = 1'b1; a_addr = 17'h0ABCD; a_wdata = 8'h99;
    wait_gnt(ga, gb);
    check("mid_gnt", ga, 1);
    @(posedge FPGA_CLK); #1;
    a_req = 1'b0;
    repeat (4) @(negedge FPGA_CLK);
    #1;
    check("mid_pre_we_b", sram_we_b, 0);
    FPGA_RST = 1'b1;
    #1;
    check("mid_we_b", sram_we_b, 1);
    check("mid_cs1_b", sram_cs1_b, 1);
    check("mid_cs2", sram_cs2, 0);
    check("mid_d_oe", sram_d_oe, 0);
    check("mid_oe_b", sram_oe_b, 1);
    @(negedge FPGA_CLK);
    FPGA_RST = 1'b0;
    exp_last_b = 1'b1;
    cnt = 0;
    repeat (15) begin @(negedge FPGA_CLK); #1; if (a_done) cnt++; end
    check("mid_no_done", cnt, 0);
    issue(1'b0, 1'b0, 17'h00030, 8'h00, rd);

    // Randomized traffic from both requesters.
    pa = 1'b0; pb = 1'b0;
    for (int t = 0; t < 60; t++) begin
      if (t < 40) begin
        if (!pa && $urandom_range(0, 2) != 0) begin
          pa = 1'b1; a_req = 1'b1; a_we = 1'($urandom_range(0, 1));
          a_addr = AW'($urandom_range(0, 15)); a_wdata = DW'($urandom);
        end
        if (!pb && $urandom_range(0, 2) != 0) begin
          pb = 1'b1; b_req = 1'b1; b_we = 1'($urandom_range(0, 1));
          b_addr = AW'($urandom_range(0, 15)); b_wdata = DW'($urandom);
        end
        if (!pa && !pb) begin
          pa = 1'b1; a_req = 1'b1; a_we = 1'b0; a_addr = AW'($urandom_range(0, 15));
        end
      end
      if (!pa && !pb) break;
      eb = pb && (!pa || !exp_last_b);
      wait_gnt(ga, gb);
      check("rand_gnt", {30'd0, ga, gb}, eb ? 32'd1 : 32'd2);
      if (eb) begin
        pb = 1'b0;
        complete(1'b1, b_we, b_addr, b_wdata, rd);
      end else begin
        pa = 1'b0;
        complete(1'b0, a_we, a_addr, a_wdata, rd);
      end
    end

    // WAIT_CYCLES=1 instance: single read.
    @(negedge FPGA_CLK);
    c_req = 1'b1; c_we = 1'b0; c_addr = 17'h00042;
    #1;
    n = 0;
    while (!c_gnt && n < 20) begin @(negedge FPGA_CLK); #1; n++; end
    check("w1_gnt", c_gnt, 1);
    s = oe1_low;
    @(posedge FPGA_CLK); #1;
    c_req = 1'b0;
    n = 0;
    do begin @(negedge FPGA_CLK); #1; n++; end while (!c_done && n < 20);
    check("w1_latency", n, 4);
    check("w1_oe_low", oe1_low - s, 1);
    check("w1_rdata", c_rdata, 8'hE7);

    check("bus_safety", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_arb_ctrl.md
Name: sram_arb_ctrl

Overview:
Dual-requester controller for the on-board asynchronous SRAM (IS62WV1288BL, 128K x 8, 55 ns access). It arbitrates two internal masters (A, B) round-robin, sequences the SRAM chip-select, output-enable and write-enable pins with programmable access timing, and returns read data. It sits between user logic and the SRAM_* top-level pins. The 8-bit bidirectional bus is split into o/oe/i, and the tristate buffer is at top level.

Parameters:
ADDR_W, 17, SRAM address width
DATA_W, 8, SRAM data width
WAIT_CYCLES, 6, FPGA_CLK cycles OE_B/WE_B held low (>=1; 6 x 10 ns covers 55 ns at 100 MHz)

Ports:
FPGA_CLK  in  1  100 MHz system clock
FPGA_RST  in  1  asynchronous, active-high reset
a_req  in  1  requester A transaction request; held until a_gnt
a_we  in  1  A: 1=write, 0=read
a_addr  in  ADDR_W  A address
a_wdata  in  DATA_W  A write data
a_gnt  out  1  A accepted (1-cycle pulse)
a_done  out  1  A transaction complete (1-cycle pulse)
a_rdata  out  DATA_W  A read data, valid with a_done on reads, held until next A read
b_req, b_we, b_addr, b_wdata, b_gnt, b_done, b_rdata  as A, for requester B
sram_a  out  ADDR_W  SRAM_A
sram_d_o  out  DATA_W  data to pins
sram_d_oe  out  1  1 = FPGA drives SRAM_D
sram_d_i  in  DATA_W  data from pins
sram_cs1_b  out  1  SRAM_CS1_B
sram_cs2  out  1  SRAM_CS2
sram_oe_b  out  1  SRAM_OE_B
sram_we_b  out  1  SRAM_WE_B

Behaviour:
- Reset values (async, immediate): sram_cs1_b=1, sram_cs2=0, sram_oe_b=1, sram_we_b=1, sram_a=0, sram_d_o=0, sram_d_oe=0, gnts=0, dones=0, rdatas=0. State=IDLE, last_grant=B so A wins the first contest.
- All SRAM pin outputs are registered. gnt is combinational in IDLE only.
- FSM: IDLE -> SETUP -> ACCESS -> HOLD -> IDLE.
- IDLE: if any req is asserted, select the winner and assert its gnt this cycle. Capture we/addr/wdata/owner at the clock edge and go to SETUP.
- Arbitration: only one req asserted, grant it. Both asserted, grant the one that is not last_grant, then update last_grant. Starvation-free alternation.
- SETUP (1 cycle): cs1_b=0, cs2=1, sram_a=captured addr, oe_b=1, we_b=1. For writes, d_oe=1 and d_o=wdata. For reads, d_oe=0.
- ACCESS (WAIT_CYCLES cycles, counter from WAIT_CYCLES-1 down to 0): read drives oe_b=0; write drives we_b=0 with data still driven. On the last ACCESS edge, reads capture sram_d_i into the owner's rdata.
- HOLD (1 cycle): oe_b=1, we_b=1, cs active, address and write data held (hold time). Then go to IDLE, release cs (cs1_b=1, cs2=0) and d_oe=0.
- The owner's done is registered and asserts for exactly the first IDLE cycle after HOLD. A new grant may occur in that same cycle (back-to-back).
- Latency: grant in cycle 0, done in cycle WAIT_CYCLES+3 (cycle 9 by default). Throughput is one transaction per WAIT_CYCLES+3 cycles.
- Bus safety: d_oe is never 1 while oe_b=0. Write-to-read turnaround is guaranteed by IDLE/SETUP with d_oe=0 before OE.
- Requests arriving outside IDLE wait. req fields are ignored after the grant edge.
- Reset mid-transaction: pins return to reset values immediately, no done is issued, and the transaction is lost.

Test Plan:
- Single write: A writes addr 0x1ABCD, data 0x5A. Required response:
  - a_gnt for 1 cycle.
  - we_b low for exactly 6 cycles with d_oe=1 and sram_a=0x1ABCD.
  - a_done 9 cycles after the grant.
  - oe_b stays 1 throughout.
- Read: SRAM model returns 0xC3 at 0x00010. B reads that address. Required response:
  - oe_b low 6 cycles and d_oe=0 throughout.
  - b_done 9 cycles after the grant, with b_rdata=0xC3.
- Contention: a_req and b_req held high continuously for 4 transactions. Required response:
  - Grants in order A, B, A, B.
  - Each grant follows the previous done in the same cycle, with a 9-cycle spacing.
- Write-then-read turnaround: A writes 0x77 to 0x00100, then B reads 0x00100. Required response:
  - b_rdata=0x77.
  - No cycle with d_oe=1 and oe_b=0 (assertion checked every cycle).
- Reset mid-op: assert FPGA_RST during cycle 3 of a write's ACCESS. Required response:
  - we_b=1, cs1_b=1, d_oe=0 immediately.
  - No a_done.
  - After release, the next A request is granted normally.
- WAIT_CYCLES=1: read. Required response: oe_b low 1 cycle and done in cycle 4 after the grant.
